// File: rtl/otp_session_if.sv
// Handshake bundle between the OTP session controller, the LFSR digit
// source and the keypad/host entry side.
interface otp_session_if #(
  parameter int unsigned MAX_ATTEMPTS = 3
);
  localparam int unsigned FC_W = $clog2(MAX_ATTEMPTS + 1);

  logic [15:0]     otp_in;
  logic            gen_req;
  logic            entry_valid;
  logic [15:0]     entry_code;
  logic [15:0]     otp_out;
  logic            otp_valid;
  logic            auth_pass;
  logic            auth_fail;
  logic            expired;
  logic            locked;
  logic [FC_W-1:0] fail_count;

  // Host / generator side
  modport master (
    output otp_in, gen_req, entry_valid, entry_code,
    input  otp_out, otp_valid, auth_pass, auth_fail, expired, locked, fail_count
  );

  // Session controller side
  modport slave (
    input  otp_in, gen_req, entry_valid, entry_code,
    output otp_out, otp_valid, auth_pass, auth_fail, expired, locked, fail_count
  );
endinterface

// File: rtl/otp_session_ctrl.sv
// OTP session controller: captures a generated 4-digit BCD code, opens a
// timed entry window, checks entries, counts failures and enforces lockout.
module otp_session_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned MAX_ATTEMPTS   = 3,
  parameter int unsigned LOCK_CYCLES    = 500
) (
  input  logic         clk,
  input  logic         reset,
  otp_session_if.slave bus
);

  localparam int unsigned FC_W   = $clog2(MAX_ATTEMPTS + 1);
  localparam int unsigned WIN_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARMED  = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [15:0]       otp_q, otp_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic              exp_q, exp_d;
  logic              valid_q, locked_q;
  logic [FC_W-1:0]   fcnt_inc;

  assign fcnt_inc = fcnt_q + FC_W'(1);

  // Next-state and output decode for the session FSM
  always_comb begin
    state_d    = state_q;
    win_cnt_d  = win_cnt_q;
    lock_cnt_d = lock_cnt_q;
    otp_d      = otp_q;
    fcnt_d     = fcnt_q;
    pass_d     = 1'b0;
    fail_d     = 1'b0;
    exp_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.gen_req) begin
          otp_d     = bus.otp_in;
          win_cnt_d = WIN_W'(TIMEOUT_CYCLES);
          fcnt_d    = '0;
          state_d   = S_ARMED;
        end
      end

      S_ARMED: begin
        if (bus.entry_valid) begin
          if (bus.entry_code == otp_q) begin
            pass_d    = 1'b1;
            otp_d     = '0;
            fcnt_d    = '0;
            win_cnt_d = '0;
            state_d   = S_IDLE;
          end else begin
            fail_d = 1'b1;
            fcnt_d = fcnt_inc;
            if (fcnt_inc == FC_W'(MAX_ATTEMPTS)) begin
              state_d    = S_LOCKED;
              lock_cnt_d = LOCK_W'(LOCK_CYCLES);
              otp_d      = '0;
              win_cnt_d  = '0;
            end else if (win_cnt_q == WIN_W'(1)) begin
              // Mismatch on the last window cycle closes the window too
              exp_d     = 1'b1;
              otp_d     = '0;
              win_cnt_d = '0;
              state_d   = S_IDLE;
            end else begin
              win_cnt_d = win_cnt_q - WIN_W'(1);
            end
          end
        end else if (bus.gen_req) begin
          // Regenerate: new code and fresh window, attempt budget kept
          otp_d     = bus.otp_in;
          win_cnt_d = WIN_W'(TIMEOUT_CYCLES);
        end else if (win_cnt_q == WIN_W'(1)) begin
          exp_d     = 1'b1;
          otp_d     = '0;
          win_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          win_cnt_d = win_cnt_q - WIN_W'(1);
        end
      end

      S_LOCKED: begin
        if (lock_cnt_q == LOCK_W'(1)) begin
          lock_cnt_d = '0;
          fcnt_d     = '0;
          state_d    = S_IDLE;
        end else begin
          lock_cnt_d = lock_cnt_q - LOCK_W'(1);
        end
      end

      default: begin
        state_d    = S_IDLE;
        win_cnt_d  = '0;
        lock_cnt_d = '0;
        otp_d      = '0;
        fcnt_d     = '0;
      end
    endcase
  end

  // State, counters and registered outputs; level outputs follow the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      win_cnt_q  <= '0;
      lock_cnt_q <= '0;
      otp_q      <= '0;
      fcnt_q     <= '0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      exp_q      <= 1'b0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_cnt_q  <= win_cnt_d;
      lock_cnt_q <= lock_cnt_d;
      otp_q      <= otp_d;
      fcnt_q     <= fcnt_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      exp_q      <= exp_d;
      valid_q    <= (state_d == S_ARMED);
      locked_q   <= (state_d == S_LOCKED);
    end
  end

  assign bus.otp_out    = otp_q;
  assign bus.otp_valid  = valid_q;
  assign bus.auth_pass  = pass_q;
  assign bus.auth_fail  = fail_q;
  assign bus.expired    = exp_q;
  assign bus.locked     = locked_q;
  assign bus.fail_count = fcnt_q;

endmodule

// File: tb/tb_otp_session_ctrl.sv
// Directed bench for otp_session_ctrl with TIMEOUT=20, MAX_ATTEMPTS=3, LOCK=10.
module tb_otp_session_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  otp_session_if #(.MAX_ATTEMPTS(3)) bus ();

  otp_session_ctrl #(
    .TIMEOUT_CYCLES(20),
    .MAX_ATTEMPTS  (3),
    .LOCK_CYCLES   (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] otp, input logic v,
                         input logic p, input logic f, input logic e,
                         input logic l, input logic [1:0] fc);
    chk({tag, ".otp_out"},    32'(bus.otp_out),    32'(otp));
    chk({tag, ".otp_valid"},  32'(bus.otp_valid),  32'(v));
    chk({tag, ".auth_pass"},  32'(bus.auth_pass),  32'(p));
    chk({tag, ".auth_fail"},  32'(bus.auth_fail),  32'(f));
    chk({tag, ".expired"},    32'(bus.expired),    32'(e));
    chk({tag, ".locked"},     32'(bus.locked),     32'(l));
    chk({tag, ".fail_count"}, 32'(bus.fail_count), 32'(fc));
  endtask

  task automatic capture(input logic [15:0] code);
    bus.otp_in  = code;
    bus.gen_req = 1'b1;
    tick();
    bus.gen_req = 1'b0;
  endtask

  task automatic enter(input logic [15:0] code);
    bus.entry_code  = code;
    bus.entry_valid = 1'b1;
    tick();
    bus.entry_valid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.otp_in      = 16'h0000;
    bus.gen_req     = 1'b0;
    bus.entry_valid = 1'b0;
    bus.entry_code  = 16'h0000;

    // Reset values
    tick();
    tick();
    chk_all("reset", 16'h0000, 0, 0, 0, 0, 0, 2'd0);
    reset = 1'b1;
    tick();

    // 1: capture, pass at window cycle 5
    capture(16'h0241);
    chk_all("t1.cap", 16'h0241, 1, 0, 0, 0, 0, 2'd0);
    repeat (4) tick();
    enter(16'h0241);
    chk_all("t1.pass", 16'h0000, 0, 1, 0, 0, 0, 2'd0);
    tick();
    chk("t1.pass_pulse_end", 32'(bus.auth_pass), 32'd0);

    // 2: window expires on the 20th armed cycle
    capture(16'h0241);
    repeat (19) begin
      chk("t2.no_early_expire", 32'(bus.expired), 32'd0);
      tick();
    end
    chk_all("t2.cycle20", 16'h0241, 1, 0, 0, 0, 0, 2'd0);
    tick();
    chk_all("t2.expired", 16'h0000, 0, 0, 0, 1, 0, 2'd0);
    tick();
    chk("t2.expire_pulse_end", 32'(bus.expired), 32'd0);
    enter(16'h0241);
    chk_all("t2.idle_entry", 16'h0000, 0, 0, 0, 0, 0, 2'd0);

    // 3: three failures lock for 10 cycles
    capture(16'h0241);
    enter(16'h1111);
    chk_all("t3.fail1", 16'h0241, 1, 0, 1, 0, 0, 2'd1);
    enter(16'h2222);
    chk_all("t3.fail2", 16'h0241, 1, 0, 1, 0, 0, 2'd2);
    enter(16'h3333);
    chk_all("t3.fail3", 16'h0000, 0, 0, 1, 0, 1, 2'd3);
    bus.gen_req     = 1'b1;
    bus.entry_valid = 1'b1;
    bus.entry_code  = 16'h0241;
    repeat (8) begin
      tick();
      chk_all("t3.lock_hold", 16'h0000, 0, 0, 0, 0, 1, 2'd3);
    end
    bus.gen_req     = 1'b0;
    bus.entry_valid = 1'b0;
    tick();
    chk_all("t3.lock_last", 16'h0000, 0, 0, 0, 0, 1, 2'd3);
    tick();
    chk_all("t3.unlocked", 16'h0000, 0, 0, 0, 0, 0, 2'd0);
    capture(16'h0241);
    chk_all("t3.recap", 16'h0241, 1, 0, 0, 0, 0, 2'd0);

    // 4: regenerate keeps fail_count and restarts the window
    enter(16'h5555);
    chk_all("t4.fail1", 16'h0241, 1, 0, 1, 0, 0, 2'd1);
    capture(16'h9876);
    chk_all("t4.regen", 16'h9876, 1, 0, 0, 0, 0, 2'd1);
    bus.otp_in = 16'h1234;
    repeat (18) tick();
    chk_all("t4.cycle19", 16'h9876, 1, 0, 0, 0, 0, 2'd1);
    enter(16'h0241);
    chk_all("t4.fail2", 16'h9876, 1, 0, 1, 0, 0, 2'd2);
    tick();
    chk_all("t4.expired", 16'h0000, 0, 0, 0, 1, 0, 2'd2);

    // 5: mismatch on the final cycle, then entry beats gen_req
    capture(16'h4321);
    chk_all("t5.cap", 16'h4321, 1, 0, 0, 0, 0, 2'd0);
    repeat (19) tick();
    enter(16'h0000);
    chk_all("t5.fail_expire", 16'h0000, 0, 0, 1, 1, 0, 2'd1);
    capture(16'h4321);
    bus.otp_in      = 16'h5678;
    bus.gen_req     = 1'b1;
    bus.entry_code  = 16'h4321;
    bus.entry_valid = 1'b1;
    tick();
    bus.gen_req     = 1'b0;
    bus.entry_valid = 1'b0;
    chk_all("t5.entry_wins", 16'h0000, 0, 1, 0, 0, 0, 2'd0);
    capture(16'h4321);
    bus.otp_in      = 16'h5678;
    bus.gen_req     = 1'b1;
    bus.entry_code  = 16'h0001;
    bus.entry_valid = 1'b1;
    tick();
    bus.gen_req     = 1'b0;
    bus.entry_valid = 1'b0;
    chk_all("t5.fail_no_recap", 16'h4321, 1, 0, 1, 0, 0, 2'd1);

    // 6: reset mid-window and mid-lockout
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk_all("t6.rst_window", 16'h0000, 0, 0, 0, 0, 0, 2'd0);
    tick();
    reset = 1'b1;
    tick();
    chk_all("t6.after_rst1", 16'h0000, 0, 0, 0, 0, 0, 2'd0);
    capture(16'h0241);
    chk_all("t6.cap1", 16'h0241, 1, 0, 0, 0, 0, 2'd0);
    enter(16'h1111);
    enter(16'h2222);
    enter(16'h3333);
    chk_all("t6.locked", 16'h0000, 0, 0, 1, 0, 1, 2'd3);
    repeat (2) tick();
    reset = 1'b0;
    #1;
    chk_all("t6.rst_lock", 16'h0000, 0, 0, 0, 0, 0, 2'd0);
    tick();
    reset = 1'b1;
    capture(16'h0241);
    chk_all("t6.cap2", 16'h0241, 1, 0, 0, 0, 0, 2'd0);
    enter(16'h0241);
    chk_all("t6.pass", 16'h0000, 0, 1, 0, 0, 0, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
